// File: rtl/rom_loader_if.sv
// Byte-stream input, ROM write port and status signals of the boot ROM loader.
// master = the loader itself, slave = the surrounding system (UART, ROM, controller).
interface rom_loader_if;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic        wr_en_o;
   logic [31:0] wr_addr_o;
   logic [31:0] wr_data_o;
   logic        hold_o;
   logic        done_o;
   logic        err_o;
   logic [15:0] word_cnt_o;

   modport master (
      input  rx_data_i, rx_valid_i,
      output rx_ready_o, wr_en_o, wr_addr_o, wr_data_o, hold_o, done_o, err_o, word_cnt_o
   );

   modport slave (
      output rx_data_i, rx_valid_i,
      input  rx_ready_o, wr_en_o, wr_addr_o, wr_data_o, hold_o, done_o, err_o, word_cnt_o
   );
endinterface

// File: rtl/rom_loader.sv
// Boot ROM programmer: framed LE byte stream -> one ROM word write per 4 bytes (>=5 cycles/word), stalls input during write.
// Optional trailing XOR checksum byte when ROM_LOADER_CHECKSUM_EN is defined.
module rom_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          MAX_WORDS      = 4096,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1_000_000
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   rom_loader_if.master bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_FINISH,
      S_ERR
   } state_t;

   state_t        state;
   logic [TW-1:0] tmo;
   logic [7:0]    len_lo;
   logic [15:0]   len;
   logic [1:0]    byte_idx;
   logic [23:0]   word_lo;
   logic          rdy_q;
   logic          wr_en_q;
   logic [31:0]   wr_addr_q;
   logic [31:0]   wr_data_q;
   logic          hold_q;
   logic          done_q;
   logic          err_q;
   logic [15:0]   cnt_q;
`ifdef ROM_LOADER_CHECKSUM_EN
   logic [7:0]    chk;
`endif

   logic        xfer;
   logic [15:0] len_full;
   logic        len_bad;
   logic        in_frame;
   logic        tmo_fire;
   logic        go_err;

   assign xfer     = bus.rx_valid_i && rdy_q;
   assign len_full = {bus.rx_data_i, len_lo};
   assign len_bad  = (len_full == 16'd0) || ({16'd0, len_full} > 32'(MAX_WORDS));

`ifdef ROM_LOADER_CHECKSUM_EN
   assign in_frame = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA) || (state == S_CHECK);
   assign go_err   = tmo_fire || (state == S_LEN_HI && xfer && len_bad)
                  || (state == S_CHECK && xfer && bus.rx_data_i != chk);
`else
   assign in_frame = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
   assign go_err   = tmo_fire || (state == S_LEN_HI && xfer && len_bad);
`endif
   assign tmo_fire = in_frame && !xfer && (tmo == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= S_IDLE;
         tmo       <= '0;
         len_lo    <= '0;
         len       <= '0;
         byte_idx  <= '0;
         word_lo   <= '0;
         rdy_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         hold_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
         chk       <= '0;
`endif
      end else begin
         // Idle-gap counter only runs in states that are waiting on the sender.
         tmo <= (in_frame && !xfer) ? tmo + TW'(1) : '0;
         if (go_err) begin
            state  <= S_ERR;
            err_q  <= 1'b1;
            hold_q <= 1'b0;
            rdy_q  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  rdy_q  <= 1'b1;
                  hold_q <= 1'b0;
                  if (xfer && bus.rx_data_i == SYNC_BYTE) begin
                     state  <= S_LEN_LO;
                     err_q  <= 1'b0;
                     cnt_q  <= '0;
                     hold_q <= 1'b1;
                  end
               end
               S_LEN_LO: if (xfer) begin
                  len_lo <= bus.rx_data_i;
`ifdef ROM_LOADER_CHECKSUM_EN
                  chk    <= bus.rx_data_i;
`endif
                  state  <= S_LEN_HI;
               end
               S_LEN_HI: if (xfer) begin
                  len      <= len_full;
`ifdef ROM_LOADER_CHECKSUM_EN
                  chk      <= chk ^ bus.rx_data_i;
`endif
                  byte_idx <= '0;
                  state    <= S_DATA;
               end
               S_DATA: if (xfer) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                  chk      <= chk ^ bus.rx_data_i;
`endif
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_lo[7:0]   <= bus.rx_data_i;
                     2'd1: word_lo[15:8]  <= bus.rx_data_i;
                     2'd2: word_lo[23:16] <= bus.rx_data_i;
                     default: begin
                        rdy_q     <= 1'b0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= BASE_ADDR + {14'd0, cnt_q, 2'b00};
                        wr_data_q <= {bus.rx_data_i, word_lo};
                        state     <= S_WRITE;
                     end
                  endcase
               end
               S_WRITE: begin
                  wr_en_q <= 1'b0;
                  cnt_q   <= cnt_q + 16'd1;
                  if (16'(cnt_q + 16'd1) == len) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                     state  <= S_CHECK;
                     rdy_q  <= 1'b1;
`else
                     state  <= S_FINISH;
                     done_q <= 1'b1;
`endif
                  end else begin
                     state <= S_DATA;
                     rdy_q <= 1'b1;
                  end
               end
`ifdef ROM_LOADER_CHECKSUM_EN
               S_CHECK: if (xfer) begin
                  state  <= S_FINISH;
                  done_q <= 1'b1;
                  rdy_q  <= 1'b0;
               end
`endif
               S_FINISH: begin
                  done_q <= 1'b0;
                  hold_q <= 1'b0;
                  rdy_q  <= 1'b1;
                  state  <= S_IDLE;
               end
               S_ERR: begin
                  rdy_q <= 1'b1;
                  state <= S_IDLE;
               end
               default: begin
                  rdy_q  <= 1'b1;
                  hold_q <= 1'b0;
                  state  <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.rx_ready_o = rdy_q;
   assign bus.wr_en_o    = wr_en_q;
   assign bus.wr_addr_o  = wr_addr_q;
   assign bus.wr_data_o  = wr_data_q;
   assign bus.hold_o     = hold_q;
   assign bus.done_o     = done_q;
   assign bus.err_o      = err_q;
   assign bus.word_cnt_o = cnt_q;
endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: framed downloads, length errors, gapped input, timeout, mid-frame reset.
module tb_rom_loader;
   logic clk;
   logic rst_n;
   rom_loader_if ifc ();

   rom_loader #(
      .BASE_ADDR(32'h0000_1000),
      .MAX_WORDS(4096),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .bus(ifc)
   );

   int checks = 0;
   int failures = 0;
   int nwr = 0;
   int ndone = 0;
   int base_wr;
   int base_done;
   logic [31:0] cap_addr [64];
   logic [31:0] cap_data [64];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ifc.wr_en_o === 1'b1) begin
         if (nwr < 64) begin
            cap_addr[nwr] = ifc.wr_addr_o;
            cap_data[nwr] = ifc.wr_data_o;
         end
         nwr++;
      end
      if (ifc.done_o === 1'b1) ndone++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      ifc.rx_data_i  = b;
      ifc.rx_valid_i = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (ifc.rx_ready_o === 1'b1) break;
      end
      chk("send_ready", {31'd0, ifc.rx_ready_o}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic gap();
      ifc.rx_valid_i = 1'b0;
      step();
   endtask

   task automatic wait_done();
      for (int n = 0; n < 20 && ifc.done_o !== 1'b1; n++) step();
      chk("done_pulse", {31'd0, ifc.done_o}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      ifc.rx_valid_i = 1'b0;
      ifc.rx_data_i  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, ifc.rx_ready_o}, 32'd0);
      chk("rst_wr_en", {31'd0, ifc.wr_en_o}, 32'd0);
      chk("rst_wr_addr", ifc.wr_addr_o, 32'd0);
      chk("rst_wr_data", ifc.wr_data_o, 32'd0);
      chk("rst_hold", {31'd0, ifc.hold_o}, 32'd0);
      chk("rst_done", {31'd0, ifc.done_o}, 32'd0);
      chk("rst_err", {31'd0, ifc.err_o}, 32'd0);
      chk("rst_cnt", {16'd0, ifc.word_cnt_o}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("ready_after_rst", {31'd0, ifc.rx_ready_o}, 32'd1);

      // Two-word frame, continuous stream
      send(8'hA5);
      chk("f1_hold", {31'd0, ifc.hold_o}, 32'd1);
      send(8'h02); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      chk("f1_w0_en", {31'd0, ifc.wr_en_o}, 32'd1);
      chk("f1_w0_addr", ifc.wr_addr_o, 32'h0000_1000);
      chk("f1_w0_data", ifc.wr_data_o, 32'h1234_5678);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      chk("f1_w1_en", {31'd0, ifc.wr_en_o}, 32'd1);
      chk("f1_w1_addr", ifc.wr_addr_o, 32'h0000_1004);
`ifdef ROM_LOADER_CHECKSUM_EN
      send(8'h28);
`endif
      wait_done();
      chk("f1_hold_at_done", {31'd0, ifc.hold_o}, 32'd1);
      chk("f1_cnt", {16'd0, ifc.word_cnt_o}, 32'd2);
      gap();
      chk("f1_hold_after", {31'd0, ifc.hold_o}, 32'd0);
      chk("f1_done_one_cycle", {31'd0, ifc.done_o}, 32'd0);
      chk("f1_err", {31'd0, ifc.err_o}, 32'd0);
      chk("f1_addr_held", ifc.wr_addr_o, 32'h0000_1004);
      chk("f1_data_held", ifc.wr_data_o, 32'hDEAD_BEEF);
      chk("f1_nwr", nwr, 32'd2);
      chk("f1_cap0_addr", cap_addr[0], 32'h0000_1000);
      chk("f1_cap1_data", cap_data[1], 32'hDEAD_BEEF);
      chk("f1_ndone", ndone, 32'd1);

`ifdef ROM_LOADER_CHECKSUM_EN
      // Same frame, wrong checksum
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      send(8'h29);
      gap(); gap();
      chk("bad_chk_err", {31'd0, ifc.err_o}, 32'd1);
      chk("bad_chk_hold", {31'd0, ifc.hold_o}, 32'd0);
      chk("bad_chk_nwr", nwr, 32'd4);
      chk("bad_chk_ndone", ndone, 32'd1);
`endif

      // Zero length, then oversize length
      base_wr = nwr;
      send(8'hA5);
      chk("len0_err_cleared", {31'd0, ifc.err_o}, 32'd0);
      chk("len0_cnt_cleared", {16'd0, ifc.word_cnt_o}, 32'd0);
      send(8'h00); send(8'h00);
      chk("len0_err", {31'd0, ifc.err_o}, 32'd1);
      chk("len0_hold", {31'd0, ifc.hold_o}, 32'd0);
      chk("len0_ready_in_err", {31'd0, ifc.rx_ready_o}, 32'd0);
      send(8'hA5);
      chk("len4097_err_cleared", {31'd0, ifc.err_o}, 32'd0);
      send(8'h01); send(8'h10);
      chk("len4097_err", {31'd0, ifc.err_o}, 32'd1);
      gap(); gap();
      chk("len_err_no_write", nwr, base_wr);

      // Gapped input with leading junk
      base_wr = nwr;
      base_done = ndone;
      send(8'h11); gap(); send(8'h22); gap();
      send(8'hA5); gap(); send(8'h01); gap(); send(8'h00); gap();
      send(8'h01); gap(); send(8'h00); gap(); send(8'h00); gap(); send(8'h00);
`ifdef ROM_LOADER_CHECKSUM_EN
      gap(); send(8'h00);
`endif
      wait_done();
      gap();
      chk("gap_nwr", nwr, base_wr + 1);
      chk("gap_addr", cap_addr[base_wr], 32'h0000_1000);
      chk("gap_data", cap_data[base_wr], 32'h0000_0001);
      chk("gap_ndone", ndone, base_done + 1);
      chk("gap_cnt", {16'd0, ifc.word_cnt_o}, 32'd1);
      chk("gap_err", {31'd0, ifc.err_o}, 32'd0);

      // Stall after two data bytes
      base_wr = nwr;
      send(8'hA5); send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
      ifc.rx_valid_i = 1'b0;
      repeat (15) step();
      chk("tmo_err_before", {31'd0, ifc.err_o}, 32'd0);
      chk("tmo_hold_before", {31'd0, ifc.hold_o}, 32'd1);
      step();
      chk("tmo_err_at16", {31'd0, ifc.err_o}, 32'd1);
      chk("tmo_hold_at16", {31'd0, ifc.hold_o}, 32'd0);
      gap(); gap();
      chk("tmo_no_write", nwr, base_wr);

      // Reset during the third word
      base_wr = nwr;
      send(8'hA5); send(8'h04); send(8'h00);
      for (int i = 1; i <= 8; i++) send(8'(i));
      send(8'h09); send(8'h0A);
      chk("rstmid_two_writes", nwr, base_wr + 2);
      ifc.rx_data_i = 8'h0B;
      rst_n = 1'b0;
      #1;
      chk("rstmid_ready", {31'd0, ifc.rx_ready_o}, 32'd0);
      chk("rstmid_hold", {31'd0, ifc.hold_o}, 32'd0);
      chk("rstmid_cnt", {16'd0, ifc.word_cnt_o}, 32'd0);
      chk("rstmid_wr_addr", ifc.wr_addr_o, 32'd0);
      chk("rstmid_wr_data", ifc.wr_data_o, 32'd0);
      chk("rstmid_err", {31'd0, ifc.err_o}, 32'd0);
      repeat (3) step();
      chk("rstmid_no_write", nwr, base_wr + 2);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      base_wr = nwr;
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'h44); send(8'h33); send(8'h22); send(8'h11);
`ifdef ROM_LOADER_CHECKSUM_EN
      send(8'h45);
`endif
      wait_done();
      gap();
      chk("post_rst_nwr", nwr, base_wr + 1);
      chk("post_rst_addr", cap_addr[base_wr], 32'h0000_1000);
      chk("post_rst_data", cap_data[base_wr], 32'h1122_3344);
      chk("post_rst_cnt", {16'd0, ifc.word_cnt_o}, 32'd1);
      chk("post_rst_err", {31'd0, ifc.err_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
